eth_link_ctrl: RTL
==================

Name: eth_link_ctrl

Overview:
- Bring-up and supervision controller for the 10G SFP/QSFP Ethernet port.
- Sequences the optical module pins (reset, modsel, lpmode) and the PHY/GT reset, then monitors clock_ok and RX block lock.
- Retries link acquisition on timeout and reports a qualified link_up to the SoC.
- Sits between the riscv block's eth_clock domain and the ethernet_sfp_10g PHY wrapper; runs on the PHY init clock.

Parameters:
- CNT_W, 24, width of the shared phase/timeout counter; all cycle parameters must be < 2^CNT_W.
- DEBOUNCE_CYCLES, 1000, cycles sfp_modprs must be stable before its debounced value changes.
- RESET_CYCLES, 1000, module reset (sfp_reset low) pulse length.
- INIT_CYCLES, 2000000, module init wait after reset release.
- GT_RESET_CYCLES, 256, minimum gt_reset assertion.
- LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required to declare link up.
- LOCK_TIMEOUT, 1000000, LOCK_WAIT cycles before a GT retry.

Ports:
- clock  in  1  controller clock (PHY init clock, free-running).
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  software enable, synchronous to clock.
- sfp_modprs  in  1  module present, active-low, asynchronous.
- sfp_int  in  1  module interrupt, active-low, asynchronous.
- clock_ok  in  1  PHY clock-good, asynchronous.
- rx_block_lock  in  1  PHY RX block lock (eth_status bit 0), asynchronous.
- sfp_reset  out  1  module reset, active-low.
- sfp_modsel  out  1  module select, active-low.
- sfp_lpmode  out  1  module low-power mode.
- gt_reset  out  1  PHY/GT reset, active-high.
- link_up  out  1  qualified link status.
- irq  out  1  module interrupt pending, level.
- state  out  3  current FSM state encoding.
- retry_count  out  8  lock-timeout retries, saturating.

Behaviour:
- Reset values: sfp_reset=0, sfp_modsel=1, sfp_lpmode=1, gt_reset=1, link_up=0, irq=0, state=ABSENT(0), retry_count=0, counter=0.
- All four async inputs pass through 2-flop synchronizers (2-cycle latency).
- modprs is additionally debounced: present_db changes only after DEBOUNCE_CYCLES identical consecutive synchronized samples.
- States: ABSENT=0, MOD_RST=1, MOD_INIT=2, GT_RST=3, LOCK_WAIT=4, LINK_UP=5.
- Global priority override: from any state, (!present_db | !enable) -> ABSENT next cycle. This beats every other transition.
- ABSENT: outputs as in reset; retry_count cleared. present_db & enable -> MOD_RST with counter=0.
- MOD_RST: sfp_reset=0, modsel=0, lpmode=1. When counter==RESET_CYCLES-1 -> MOD_INIT, counter cleared.
- MOD_INIT: sfp_reset=1, lpmode=0, gt_reset=1. When counter==INIT_CYCLES-1 -> GT_RST.
- GT_RST: gt_reset=1. When counter>=GT_RESET_CYCLES-1 and clock_ok_sync=1 -> LOCK_WAIT. Counter saturates and never wraps.
- LOCK_WAIT: gt_reset=0. A stable-lock counter increments while lock_sync=1 and clears when lock_sync=0. The timeout counter runs every cycle.
  - Stable count reaching LOCK_STABLE_CYCLES -> LINK_UP.
  - Otherwise timeout reaching LOCK_TIMEOUT-1 -> GT_RST, retry_count+1 (saturate at 255).
  - If both occur on the same cycle, LINK_UP wins.
  - clock_ok_sync=0 -> GT_RST without incrementing retry_count.
- LINK_UP: link_up=1, registered, asserted the cycle the state is entered.
  - lock_sync=0 -> LOCK_WAIT (counters cleared).
  - clock_ok_sync=0 -> GT_RST; clock_ok has priority over lock.
- link_up=1 only in LINK_UP.
- irq = int_sync low & state!=ABSENT, registered (3 cycles from pin).
- The counter clears on every state change.
- resetn asserted mid-sequence returns all outputs to reset values immediately (asynchronous).

Optional Feature:
- Macro: ETH_LINK_CTRL_STATS_EN.
- When defined: adds output link_down_count (16 bits). It increments by 1 on each exit from LINK_UP for any reason, saturates at 0xFFFF, resets to 0 on resetn, and is not cleared by ABSENT.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package eth_link_ctrl_pkg: state enum (3-bit, values above), STATE_W=3, RETRY_W=8, LDCNT_W=16.
- One sub-module, eth_link_sync_debounce: 2-flop synchronizer plus an optional debounce counter (DEBOUNCE_CYCLES parameter, 0 = sync only). Instantiated four times: debounce on modprs, 0 on the other three.

Test Plan (DEBOUNCE=4, RESET=4, INIT=8, GT_RESET=4, LOCK_STABLE=3, LOCK_TIMEOUT=20):
- Bring-up: enable=1, modprs low at t0, clock_ok=1, lock=1.
  - Expect sfp_reset low for exactly 4 cycles after debounce.
  - Expect gt_reset to fall after 8 init + 4 GT cycles.
  - Expect link_up=1 exactly 3 cycles after LOCK_WAIT entry plus sync latency.
- No lock: lock held 0.
  - Expect GT_RST re-entry every 20 LOCK_WAIT cycles and retry_count incrementing 1,2,3.
  - Force 300 retries: retry_count saturates at 255.
- Module pull: from LINK_UP, modprs high 3 cycles then low -> no state change (debounce).
  - Hold high ≥6 cycles -> state=ABSENT, link_up=0, sfp_reset=0, retry_count=0.
- Link drop: in LINK_UP, drop lock for 1 cycle -> state LOCK_WAIT, link_up=0.
  - Restore lock -> LINK_UP after 3 stable cycles.
  - With ETH_LINK_CTRL_STATS_EN: link_down_count=1.
- Priorities: clock_ok and lock drop on the same cycle in LINK_UP -> GT_RST, retry_count unchanged.
  - enable=0 in MOD_INIT -> ABSENT next cycle.
- Async reset mid-GT_RST: assert resetn=0 between clock edges -> all outputs reach reset values before the next edge.
  - irq: sfp_int low in LINK_UP -> irq=1 after 3 cycles; irq stays 0 in ABSENT.

Source files
------------

// File: rtl/eth_link_ctrl_pkg.sv
// Shared types for the 10G SFP/QSFP link controller: FSM states,
// counter widths and the per-state pin decode.
package eth_link_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 8;
    localparam int LDCNT_W = 16;

    typedef enum logic [STATE_W-1:0] {
        ABSENT    = 3'd0,
        MOD_RST   = 3'd1,
        MOD_INIT  = 3'd2,
        GT_RST    = 3'd3,
        LOCK_WAIT = 3'd4,
        LINK_UP   = 3'd5
    } link_state_t;

    typedef struct packed {
        logic sfp_reset;
        logic sfp_modsel;
        logic sfp_lpmode;
        logic gt_reset;
        logic link_up;
    } pin_t;

    localparam pin_t PIN_RST = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic pin_t pins_for(link_state_t s);
        pin_t p;
        p = PIN_RST;
        case (s)
            ABSENT:           p = PIN_RST;
            MOD_RST:          p = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            MOD_INIT, GT_RST: p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            LOCK_WAIT:        p = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            LINK_UP:          p = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            default:          p = PIN_RST;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/eth_link_ctrl_if.sv
// Optical module and PHY pin bundle between the link controller
// (master) and the SFP cage / PHY wrapper (slave).
interface eth_link_ctrl_if;

    logic sfp_modprs;
    logic sfp_int;
    logic clock_ok;
    logic rx_block_lock;
    logic sfp_reset;
    logic sfp_modsel;
    logic sfp_lpmode;
    logic gt_reset;

    modport master (
        input  sfp_modprs, sfp_int, clock_ok, rx_block_lock,
        output sfp_reset, sfp_modsel, sfp_lpmode, gt_reset
    );

    modport slave (
        output sfp_modprs, sfp_int, clock_ok, rx_block_lock,
        input  sfp_reset, sfp_modsel, sfp_lpmode, gt_reset
    );

endinterface

// File: rtl/eth_link_sync_debounce.sv
// Two-flop synchronizer with an optional stability filter;
// DEBOUNCE_CYCLES=0 gives a plain synchronizer.
module eth_link_sync_debounce #(
    parameter int   CNT_W           = 24,
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_sync
            assign dout = sync_q[1];
        end else begin : g_db
            logic [CNT_W-1:0] cnt_q;
            logic             db_q;

            // cnt_q counts consecutive samples that disagree with db_q
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    cnt_q <= '0;
                    db_q  <= RST_VAL;
                end else if (sync_q[1] == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q <= '0;
                    db_q  <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            assign dout = db_q;
        end
    endgenerate

endmodule

// File: rtl/eth_link_ctrl.sv
// SFP/QSFP 10G link bring-up and supervision controller.
// Optional link-down statistics: define ETH_LINK_CTRL_STATS_EN.
module eth_link_ctrl
    import eth_link_ctrl_pkg::*;
#(
    parameter int CNT_W              = 24,
    parameter int DEBOUNCE_CYCLES    = 1000,
    parameter int RESET_CYCLES       = 1000,
    parameter int INIT_CYCLES        = 2000000,
    parameter int GT_RESET_CYCLES    = 256,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 1000000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    eth_link_ctrl_if.master      phy,
    output logic                 link_up,
    output logic                 irq,
    output logic [STATE_W-1:0]   state,
    output logic [RETRY_W-1:0]   retry_count
`ifdef ETH_LINK_CTRL_STATS_EN
    ,
    output logic [LDCNT_W-1:0]   link_down_count
`endif
);

    logic modprs_db;
    logic int_s;
    logic ok_s;
    logic lock_s;
    logic present_db;

    eth_link_sync_debounce #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)
    ) u_modprs (
        .clock(clock), .resetn(resetn), .din(phy.sfp_modprs), .dout(modprs_db)
    );

    eth_link_sync_debounce #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(0), .RST_VAL(1'b1)
    ) u_int (
        .clock(clock), .resetn(resetn), .din(phy.sfp_int), .dout(int_s)
    );

    eth_link_sync_debounce #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(0), .RST_VAL(1'b0)
    ) u_ok (
        .clock(clock), .resetn(resetn), .din(phy.clock_ok), .dout(ok_s)
    );

    eth_link_sync_debounce #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(0), .RST_VAL(1'b0)
    ) u_lock (
        .clock(clock), .resetn(resetn), .din(phy.rx_block_lock), .dout(lock_s)
    );

    assign present_db = ~modprs_db;

    link_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    pin_t             pins_q;
    logic             irq_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        stable_d = '0;
        retry_d  = retry_q;
        case (state_q)
            ABSENT: begin
                cnt_d = '0;
                if (present_db && enable) state_d = MOD_RST;
            end
            MOD_RST: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) state_d = MOD_INIT;
            end
            MOD_INIT: begin
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) state_d = GT_RST;
            end
            GT_RST: begin
                if (cnt_q >= CNT_W'(GT_RESET_CYCLES - 1)) begin
                    cnt_d = cnt_q;
                    if (ok_s) state_d = LOCK_WAIT;
                end
            end
            LOCK_WAIT: begin
                stable_d = lock_s ? stable_q + CNT_W'(1) : '0;
                if (!ok_s) begin
                    state_d = GT_RST;
                end else if (lock_s &&
                    stable_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = LINK_UP;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = GT_RST;
                    if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
                end
            end
            LINK_UP: begin
                cnt_d = '0;
                if (!ok_s) state_d = GT_RST;
                else if (!lock_s) state_d = LOCK_WAIT;
            end
            default: state_d = ABSENT;
        endcase
        // loss of module or software enable overrides everything
        if (!present_db || !enable) state_d = ABSENT;
        if (state_d == ABSENT) retry_d = '0;
        if (state_d != state_q) begin
            cnt_d    = '0;
            stable_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ABSENT;
            cnt_q    <= '0;
            stable_q <= '0;
            retry_q  <= '0;
            pins_q   <= PIN_RST;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            retry_q  <= retry_d;
            pins_q   <= pins_for(state_d);
            irq_q    <= ~int_s && (state_q != ABSENT);
        end
    end

`ifdef ETH_LINK_CTRL_STATS_EN
    logic [LDCNT_W-1:0] ldc_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ldc_q <= '0;
        end else if (state_q == LINK_UP && state_d != LINK_UP &&
                     ldc_q != '1) begin
            ldc_q <= ldc_q + LDCNT_W'(1);
        end
    end

    assign link_down_count = ldc_q;
`endif

    assign phy.sfp_reset  = pins_q.sfp_reset;
    assign phy.sfp_modsel = pins_q.sfp_modsel;
    assign phy.sfp_lpmode = pins_q.sfp_lpmode;
    assign phy.gt_reset   = pins_q.gt_reset;
    assign link_up        = pins_q.link_up;
    assign irq            = irq_q;
    assign state          = state_q;
    assign retry_count    = retry_q;

endmodule
